// File: rtl/fifo_read_master.sv
// rtl/fifo_read_master.sv - syn_fifo read-side consumer feeding a valid/ready stream via a 2-entry skid buffer
// Optional macro FIFO_RD_COUNT_EN adds the rd_count_o transferred-word counter.
module fifo_read_master #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  fifo_empty_i,
    input  logic                  half_full_i,
    output logic                  rd_o,
    output logic                  oe_o,
    input  logic [DATA_WIDTH-1:0] data_out_i,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i,
    output logic                  busy_o
`ifdef FIFO_RD_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  rd_count_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_rd;
    logic                  r_inflight;
    logic                  r_oe;
    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_head;
    logic [1:0]            r_occ;
    logic [1:0]            w_occ_next;
    logic                  w_push;
    logic                  w_push_ok;
    logic                  w_pop;
    logic                  w_wr_idx;
    logic                  w_credit;
    logic                  w_rd_issue;

    if (CNT_WIDTH < 1) begin : g_cnt_width_invalid
    end

    assign w_push    = r_inflight;
    assign w_pop     = (r_occ != 2'd0) & m_ready_i;
    assign w_push_ok = w_push & (r_occ != 2'd2);
    assign w_wr_idx  = r_head ^ r_occ[0];

    always_comb begin
        w_occ_next = r_occ;
        if (w_push_ok && !w_pop) begin
            w_occ_next = r_occ + 2'd1;
        end else if (!w_push_ok && w_pop) begin
            w_occ_next = r_occ - 2'd1;
        end
    end

    // r_rd is both the word about to be in flight and the spacing flag for the next decision.
    assign w_credit   = (({1'b0, w_occ_next} + {2'b00, r_rd}) < 3'd2);
    assign w_rd_issue = (r_state == S_RUN) & en_i & ~fifo_empty_i & w_credit
                      & (~r_rd | half_full_i);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (en_i) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (!en_i) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (en_i) begin
                    w_state_next = S_RUN;
                end else if (!r_inflight && (r_occ == 2'd0)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state    <= S_IDLE;
            r_rd       <= 1'b0;
            r_inflight <= 1'b0;
            r_oe       <= 1'b0;
            r_head     <= 1'b0;
            r_occ      <= 2'd0;
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_rd       <= w_rd_issue;
            r_inflight <= r_rd;
            r_oe       <= (w_state_next != S_IDLE);
            r_occ      <= w_occ_next;
            if (w_pop) begin
                r_head <= ~r_head;
            end
            // A push arriving while full is dropped; the credit check keeps it from happening.
            if (w_push_ok) begin
                r_mem[w_wr_idx] <= data_out_i;
            end
        end
    end

`ifdef FIFO_RD_COUNT_EN
    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_count <= '0;
        end else if (w_push_ok) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign rd_count_o = r_count;
`endif

    assign rd_o      = r_rd;
    assign oe_o      = r_oe;
    assign m_valid_o = (r_occ != 2'd0);
    assign m_data_o  = r_mem[r_head];
    assign busy_o    = (r_state != S_IDLE);

endmodule

// File: tb/tb_fifo_read_master.sv
// tb/tb_fifo_read_master.sv - self-checking bench for fifo_read_master with a queue-based FIFO and stream scoreboard
// Exercises rd_count_o when FIFO_RD_COUNT_EN is defined.
module tb_fifo_read_master;

    localparam int DW    = 16;
    localparam int CW    = 4;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic          en_i;
    logic          fifo_empty_i;
    logic          half_full_i;
    logic          rd_o;
    logic          oe_o;
    logic [DW-1:0] data_out_i;
    logic          m_valid_o;
    logic [DW-1:0] m_data_o;
    logic          m_ready_i;
    logic          busy_o;
`ifdef FIFO_RD_COUNT_EN
    logic [CW-1:0] rd_count_o;
`endif

    always #5 clk = ~clk;

    fifo_read_master #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .en_i        (en_i),
        .fifo_empty_i(fifo_empty_i),
        .half_full_i (half_full_i),
        .rd_o        (rd_o),
        .oe_o        (oe_o),
        .data_out_i  (data_out_i),
        .m_valid_o   (m_valid_o),
        .m_data_o    (m_data_o),
        .m_ready_i   (m_ready_i),
        .busy_o      (busy_o)
`ifdef FIFO_RD_COUNT_EN
        ,
        .rd_count_o  (rd_count_o)
`endif
    );

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] sb[$];
    bit            pend;
    bit            hold;
    logic [DW-1:0] hold_data;
    bit            prev_rd, prev_empty, prev_hf, prev_en, prev_rst;
    int            rd_total;
    int            acc_total;
    int            cyc;

    task automatic set_flags();
        fifo_empty_i = (fq.size() == 0);
        half_full_i  = (fq.size() >= DEPTH / 2);
    endtask

    task automatic load_fifo(input int n);
        for (int i = 0; i < n; i++) fq.push_back(DW'($urandom));
        set_flags();
    endtask

    // One clock: scoreboard the handshake at the coming edge, then model the FIFO at the next negedge.
    task automatic tick();
        logic [DW-1:0] w;
        if (rst_n_i && m_valid_o && m_ready_i) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL stream_extra: got word %h, required no word", m_data_o);
            end else begin
                w = sb.pop_front();
                if (m_data_o !== w) begin
                    errors++;
                    $display("FAIL stream_data: got %h required %h", m_data_o, w);
                end
            end
            acc_total++;
        end
        hold       = rst_n_i && m_valid_o && !m_ready_i;
        hold_data  = m_data_o;
        prev_rd    = rd_o;
        prev_empty = fifo_empty_i;
        prev_hf    = half_full_i;
        prev_en    = en_i;
        prev_rst   = rst_n_i;
        @(negedge clk);
        cyc++;
        if (!prev_rst) begin
            if (pend && fq.size() > 0) void'(fq.pop_front());
            pend       = 1'b0;
            hold       = 1'b0;
            sb.delete();
            rd_total   = acc_total;
            data_out_i = DW'($urandom);
            set_flags();
        end else begin
            if (hold) begin
                checks++;
                if (m_valid_o !== 1'b1 || m_data_o !== hold_data) begin
                    errors++;
                    $display("FAIL hold_stable: got valid=%b data=%h required valid=1 data=%h",
                             m_valid_o, m_data_o, hold_data);
                end
            end
            if (pend) begin
                checks++;
                if (fq.size() == 0) begin
                    errors++;
                    $display("FAIL fifo_underflow: got read of empty FIFO, required none");
                    data_out_i = DW'($urandom);
                end else begin
                    w = fq.pop_front();
                    data_out_i = w;
                    sb.push_back(w);
                end
            end else begin
                data_out_i = DW'($urandom);
            end
            set_flags();
            pend = rd_o;
            if (rd_o === 1'b1) begin
                rd_total++;
                checks++;
                if (prev_empty || !prev_en || (prev_rd && !prev_hf) || !busy_o ||
                    (rd_total - acc_total) > 2) begin
                    errors++;
                    $display("FAIL rd_rule: got rd with empty=%b en=%b prev_rd=%b hf=%b busy=%b outstanding=%0d, required legal rd with outstanding<=2",
                             prev_empty, prev_en, prev_rd, prev_hf, busy_o, rd_total - acc_total);
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n_i   = 1'b0;
        en_i      = 1'b0;
        m_ready_i = 1'b0;
        fq.delete();
        set_flags();
        tick();
        tick();
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n_i   = 1'b0;
        en_i      = 1'b1;
        m_ready_i = 1'b1;
        load_fifo(3);
        tick();
        tick();
        checks++;
        if (rd_o !== 1'b0 || oe_o !== 1'b0 || m_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got rd=%b oe=%b valid=%b busy=%b required all 0",
                     rd_o, oe_o, m_valid_o, busy_o);
        end
        checks++;
        if (m_data_o !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", m_data_o);
        end
`ifdef FIFO_RD_COUNT_EN
        checks++;
        if (rd_count_o !== '0) begin
            errors++;
            $display("FAIL reset_count: got %0d required 0", rd_count_o);
        end
`endif
        rst_n_i = 1'b1;
        en_i    = 1'b0;
        fq.delete();
        set_flags();
        tick();
    endtask

    task automatic test_single_word();
        int rd_cyc, val_cyc, nrd, base;
        logic [DW-1:0] vdata;
        do_reset();
        fq.push_back(16'hA5A5);
        set_flags();
        en_i      = 1'b1;
        m_ready_i = 1'b1;
        rd_cyc = -1; val_cyc = -1; nrd = 0; base = acc_total; vdata = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rd_o === 1'b1) begin
                nrd++;
                if (rd_cyc < 0) rd_cyc = cyc;
            end
            if (m_valid_o === 1'b1 && val_cyc < 0) begin
                val_cyc = cyc;
                vdata   = m_data_o;
            end
        end
        checks++;
        if (nrd != 1) begin
            errors++;
            $display("FAIL single_rd_count: got %0d required 1", nrd);
        end
        checks++;
        if (rd_cyc < 0 || val_cyc - rd_cyc != 2) begin
            errors++;
            $display("FAIL single_latency: got %0d required 2", val_cyc - rd_cyc);
        end
        checks++;
        if (vdata !== 16'hA5A5 || acc_total - base != 1) begin
            errors++;
            $display("FAIL single_data: got %h (accepted %0d) required a5a5 (accepted 1)",
                     vdata, acc_total - base);
        end
        en_i = 1'b0;
        for (int i = 0; i < 30 && busy_o; i++) tick();
        checks++;
        if (busy_o !== 1'b0 || oe_o !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy=%b oe=%b required 0 0", busy_o, oe_o);
        end
    endtask

    task automatic test_reset_midstream();
        int n, base, stale;
        bit seen;
        do_reset();
        load_fifo(5);
        en_i      = 1'b1;
        m_ready_i = 1'b1;
        n = 0; seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (rd_o === 1'b1) n++;
            if (n == 3) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midrst_third_rd: got %0d rd pulses required 3", n);
        end
        rst_n_i   = 1'b0;
        en_i      = 1'b0;
        m_ready_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        checks++;
        if (rd_o !== 1'b0 || oe_o !== 1'b0 || m_valid_o !== 1'b0 || busy_o !== 1'b0 ||
            m_data_o !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got rd=%b oe=%b valid=%b busy=%b data=%h required all 0",
                     rd_o, oe_o, m_valid_o, busy_o, m_data_o);
        end
        m_ready_i = 1'b1;
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (m_valid_o !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL midrst_stale: got %0d stale valid cycles required 0", stale);
        end
        en_i = 1'b1;
        base = acc_total;
        for (int i = 0; i < 60 && (acc_total - base) < 2; i++) tick();
        checks++;
        if (acc_total - base != 2 || fq.size() != 0) begin
            errors++;
            $display("FAIL midrst_resume: got %0d words (fifo left %0d) required 2 (0)",
                     acc_total - base, fq.size());
        end
        en_i = 1'b0;
        for (int i = 0; i < 30 && busy_o; i++) tick();
    endtask

    task automatic test_streaming();
        int base, b2b;
        bit lr;
        do_reset();
        load_fifo(600);
        en_i      = 1'b1;
        m_ready_i = 1'b1;
        base = acc_total; b2b = 0; lr = 1'b0;
        for (int i = 0; i < 5000 && (acc_total - base) < 600; i++) begin
            tick();
            if (rd_o === 1'b1 && lr) b2b++;
            lr = (rd_o === 1'b1);
        end
        checks++;
        if (acc_total - base != 600 || fq.size() != 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL stream_count: got %0d delivered (fifo %0d, pending %0d) required 600 (0, 0)",
                     acc_total - base, fq.size(), sb.size());
        end
        checks++;
        if (b2b == 0) begin
            errors++;
            $display("FAIL stream_b2b: got %0d back-to-back reads required >0 while half full", b2b);
        end
        en_i = 1'b0;
        for (int i = 0; i < 30 && busy_o; i++) tick();
    endtask

    task automatic test_backpressure();
        int n, base;
        do_reset();
        load_fifo(10);
        en_i      = 1'b1;
        m_ready_i = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rd_o === 1'b1) n++;
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL bp_rd_count: got %0d required 2", n);
        end
        checks++;
        if (m_valid_o !== 1'b1 || sb.size() != 2 || m_data_o !== sb[0]) begin
            errors++;
            $display("FAIL bp_head: got valid=%b data=%h buffered=%0d required valid=1 first word, 2 buffered",
                     m_valid_o, m_data_o, sb.size());
        end
        m_ready_i = 1'b1;
        base = acc_total;
        for (int i = 0; i < 200 && (acc_total - base) < 10; i++) tick();
        checks++;
        if (acc_total - base != 10 || fq.size() != 0) begin
            errors++;
            $display("FAIL bp_release: got %0d words required 10", acc_total - base);
        end
        en_i = 1'b0;
        for (int i = 0; i < 30 && busy_o; i++) tick();
    endtask

    task automatic test_drain();
        int n, base_rd, base_acc;
        bit busy_ok;
        do_reset();
        load_fifo(10);
        en_i      = 1'b1;
        m_ready_i = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && n < 2; i++) begin
            tick();
            if (rd_o === 1'b1) n++;
        end
        en_i     = 1'b0;
        base_rd  = rd_total;
        base_acc = acc_total;
        busy_ok  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy_o !== 1'b1) busy_ok = 1'b0;
        end
        checks++;
        if (!busy_ok || n != 2) begin
            errors++;
            $display("FAIL drain_busy: got busy_held=%b rds=%0d required 1 and 2", busy_ok, n);
        end
        m_ready_i = 1'b1;
        for (int i = 0; i < 20 && busy_o; i++) tick();
        checks++;
        if (rd_total != base_rd || acc_total - base_acc != 2) begin
            errors++;
            $display("FAIL drain_words: got %0d new rd and %0d accepted required 0 and 2",
                     rd_total - base_rd, acc_total - base_acc);
        end
        checks++;
        if (busy_o !== 1'b0 || oe_o !== 1'b0 || m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle: got busy=%b oe=%b valid=%b required 0 0 0",
                     busy_o, oe_o, m_valid_o);
        end
    endtask

`ifdef FIFO_RD_COUNT_EN
    task automatic test_count();
        int base, exp_cnt;
        do_reset();
        load_fifo(18);
        en_i      = 1'b1;
        m_ready_i = 1'b1;
        base = acc_total;
        for (int i = 0; i < 200 && (acc_total - base) < 18; i++) tick();
        exp_cnt = (acc_total - base) % (1 << CW);
        checks++;
        if (rd_count_o !== CW'(exp_cnt) || acc_total - base != 18) begin
            errors++;
            $display("FAIL count_wrap: got %0d required %0d", rd_count_o, 18 % (1 << CW));
        end
        en_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        en_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        en_i = 1'b0;
        for (int i = 0; i < 30 && busy_o; i++) tick();
        checks++;
        if (rd_count_o !== CW'(exp_cnt)) begin
            errors++;
            $display("FAIL count_en_toggle: got %0d required %0d", rd_count_o, exp_cnt);
        end
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        checks++;
        if (rd_count_o !== '0) begin
            errors++;
            $display("FAIL count_reset: got %0d required 0", rd_count_o);
        end
    endtask
`endif

    initial begin
        rst_n_i      = 1'b0;
        en_i         = 1'b0;
        m_ready_i    = 1'b0;
        data_out_i   = '0;
        fifo_empty_i = 1'b1;
        half_full_i  = 1'b0;
        pend         = 1'b0;
        hold         = 1'b0;
        hold_data    = '0;
        rd_total     = 0;
        acc_total    = 0;
        cyc          = 0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_reset_midstream();
        test_streaming();
        test_backpressure();
        test_drain();
`ifdef FIFO_RD_COUNT_EN
        test_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
